mem_lsu_ctrl: RTL and testbench

- MEM-stage load/store controller for the MIPS pipeline.
- Store path narrows register data to byte/halfword lanes and generates byte enables. This is the inverse of the extension performed on the datapath side.
- Load path extracts the addressed lane from the memory word and sign- or zero-extends it to 32 bits.
- Handshakes with a variable-latency data memory (req/ack) and stalls the pipeline until the access completes.

---
 rtl/mem_lsu_ctrl_pkg.sv | 38 +++
 rtl/mem_lsu_ctrl_load_extract.sv | 36 +++
 rtl/mem_lsu_ctrl.sv | 139 +++++++++++++
 tb/tb_mem_lsu_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_lsu_ctrl_pkg.sv
// Shared definitions for the MEM-stage load/store controller: access size codes,
// FSM encoding, byte-enable patterns and the alignment/lane helpers.
package mem_lsu_ctrl_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_B0   = 4'b0001;
    localparam logic [3:0] BE_HLO  = 4'b0011;
    localparam logic [3:0] BE_HHI  = 4'b1100;
    localparam logic [3:0] BE_WORD = 4'b1111;

    function automatic logic access_illegal(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_BYTE: access_illegal = 1'b0;
            SZ_HALF: access_illegal = lo[0];
            SZ_WORD: access_illegal = |lo;
            default: access_illegal = 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_BYTE: byte_enables = BE_B0 << lo;
            SZ_HALF: byte_enables = lo[1] ? BE_HHI : BE_HLO;
            SZ_WORD: byte_enables = BE_WORD;
            default: byte_enables = BE_NONE;
        endcase
    endfunction

endpackage

// File: rtl/mem_lsu_ctrl_load_extract.sv
// Selects the addressed byte/halfword lane of a memory word and sign- or
// zero-extends it to 32 bits.
module mem_lsu_ctrl_load_extract
    import mem_lsu_ctrl_pkg::*;
(
    input  logic [31:0] dm_rdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        ld_unsigned,
    output logic [31:0] ld_data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic        fill_b;
    logic        fill_h;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_lane = dm_rdata[7:0];
            2'd1:    byte_lane = dm_rdata[15:8];
            2'd2:    byte_lane = dm_rdata[23:16];
            default: byte_lane = dm_rdata[31:24];
        endcase
        half_lane = addr_lo[1] ? dm_rdata[31:16] : dm_rdata[15:0];
        fill_b    = ~ld_unsigned & byte_lane[7];
        fill_h    = ~ld_unsigned & half_lane[15];

        case (size)
            SZ_BYTE: ld_data = {{24{fill_b}}, byte_lane};
            SZ_HALF: ld_data = {{16{fill_h}}, half_lane};
            default: ld_data = dm_rdata;
        endcase
    end

endmodule

// File: rtl/mem_lsu_ctrl.sv
// MEM-stage load/store controller: packs store lanes, extends load lanes and
// stalls the pipeline across a req/ack handshake with variable-latency memory.
module mem_lsu_ctrl
    import mem_lsu_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_en,
    input  logic              mem_wr,
    input  logic [1:0]        size,
    input  logic              ld_unsigned,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata_out,
    output logic              stall,
    output logic              addr_err,
    output logic              dm_req,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [3:0]        dm_be,
    output logic [31:0]       dm_wdata,
    input  logic [31:0]       dm_rdata,
    input  logic              dm_ack
);

    logic [1:0]        state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [1:0]        lo_q, lo_d;
    logic [31:0]       ld_data;

    function automatic logic [31:0] pack_store(input logic [1:0] sz, input logic [31:0] wd);
        case (sz)
            SZ_BYTE: pack_store = {4{wd[7:0]}};
            SZ_HALF: pack_store = {2{wd[15:0]}};
            default: pack_store = wd;
        endcase
    endfunction

    mem_lsu_ctrl_load_extract u_load_extract (
        .dm_rdata    (dm_rdata),
        .addr_lo     (lo_q),
        .size        (size_q),
        .ld_unsigned (uns_q),
        .ld_data     (ld_data)
    );

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        size_d   = size_q;
        uns_d    = uns_q;
        lo_d     = lo_q;
        stall    = 1'b0;
        addr_err = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (mem_en) begin
                    if (access_illegal(size, addr[1:0])) begin
                        addr_err = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        state_d = ST_REQ;
                        req_d   = 1'b1;
                        we_d    = mem_wr;
                        size_d  = size;
                        uns_d   = ld_unsigned;
                        lo_d    = addr[1:0];
                        addr_d  = {addr[ADDR_W-1:2], 2'b00};
                        be_d    = byte_enables(size, addr[1:0]);
                        wdata_d = pack_store(size, wdata);
                    end
                end
            end
            ST_REQ: begin
                stall = 1'b1;
                if (dm_ack) begin
                    state_d = ST_DONE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    if (!we_q) begin
                        rdata_d = ld_data;
                    end
                end
            end
            // One free cycle lets the pipeline advance; the instruction still presented is ignored.
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= BE_NONE;
            wdata_q <= '0;
            rdata_q <= '0;
            size_q  <= SZ_BYTE;
            uns_q   <= 1'b0;
            lo_q    <= 2'b00;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            lo_q    <= lo_d;
        end
    end

    assign dm_req    = req_q;
    assign dm_we     = we_q;
    assign dm_addr   = addr_q;
    assign dm_be     = be_q;
    assign dm_wdata  = wdata_q;
    assign rdata_out = rdata_q;

endmodule

// File: tb/tb_mem_lsu_ctrl.sv
// Scoreboard bench for mem_lsu_ctrl: a driver issues accesses and queues the
// expected memory requests, latencies and load results; a memory responder pops them.
module tb_mem_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_en = 1'b0;
    logic        mem_wr = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        ld_unsigned = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata_out;
    logic        stall;
    logic        addr_err;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata = 32'h0;
    logic        dm_ack;
    logic        ack_r = 1'b0;
    logic        force_ack = 1'b0;

    assign dm_ack = ack_r | force_ack;

    mem_lsu_ctrl #(.ADDR_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_en      (mem_en),
        .mem_wr      (mem_wr),
        .size        (size),
        .ld_unsigned (ld_unsigned),
        .addr        (addr),
        .wdata       (wdata),
        .rdata_out   (rdata_out),
        .stall       (stall),
        .addr_err    (addr_err),
        .dm_req      (dm_req),
        .dm_we       (dm_we),
        .dm_addr     (dm_addr),
        .dm_be       (dm_be),
        .dm_wdata    (dm_wdata),
        .dm_rdata    (dm_rdata),
        .dm_ack      (dm_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
    } req_t;

    req_t        exp_req_q[$];
    int          dly_q[$];
    logic [31:0] rd_q[$];
    logic [31:0] exp_rd_q[$];
    logic        exp_err_q[$];
    int          issued_cnt = 0;
    bit          abort_mode = 1'b0;
    logic [31:0] last_ld = 32'h0;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: plain arithmetic on lane counts and byte offsets.
    function automatic logic m_legal(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd3) return 1'b0;
        return (a % (32'd1 << sz)) == 32'd0;
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
        int n;
        n = 1 << sz;
        return 4'(((1 << n) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] m_wd(input logic [1:0] sz, input logic [31:0] wd);
        int n;
        logic [31:0] r;
        n = 1 << sz;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_ld(input logic [1:0] sz, input logic uns,
                                         input logic [31:0] a, input logic [31:0] rd);
        int bits;
        logic [63:0] v;
        bits = 8 * (1 << sz);
        v = {32'h0, rd >> (8 * (a % 4))} & ((64'd1 << bits) - 64'd1);
        if (!uns && v[bits-1]) v = v - (64'd1 << bits);
        return v[31:0];
    endfunction

    task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int dly, input logic [31:0] rd);
        int  n;
        int  exp_n;
        bit  done;
        logic legal;
        req_t r;
        legal = m_legal(sz, a);
        if (legal) begin
            r.we = wr;
            r.addr = a & ~32'h3;
            r.be = m_be(sz, a);
            r.wd = wr ? m_wd(sz, wd) : m_wd(2'd2, wd);
            if (!wr) r.wd = m_wd(sz, wd);
            exp_req_q.push_back(r);
            dly_q.push_back(dly);
            rd_q.push_back(rd);
            if (!wr) last_ld = m_ld(sz, uns, a, rd);
            exp_rd_q.push_back(last_ld);
            exp_n = dly + 2;
        end else begin
            exp_n = 0;
        end
        exp_err_q.push_back(!legal);
        @(posedge clk);
        #1;
        mem_en = 1'b1;
        mem_wr = wr;
        size = sz;
        ld_unsigned = uns;
        addr = a;
        wdata = wd;
        issued_cnt++;
        n = 0;
        done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!legal && i == 0) chk("no_req_on_err", {71'h0, dm_req}, 72'h0);
            if (stall === 1'b1) n++;
            else begin
                done = 1'b1;
                break;
            end
        end
        if (!done) chk("stall_timeout", {71'h0, stall}, 72'h0);
        else chk("stall_cycles", 72'(n), 72'(exp_n));
    endtask

    task automatic bubble();
        @(posedge clk);
        #1;
        mem_en = 1'b0;
        size = 2'($urandom);
        addr = $urandom;
        @(negedge clk);
        chk("bubble_stall", {71'h0, stall}, 72'h0);
    endtask

    // addr_err monitor: one expectation per presented instruction, zero otherwise.
    initial begin
        int seen;
        seen = 0;
        forever begin
            @(negedge clk);
            if (issued_cnt != seen) begin
                seen = issued_cnt;
                if (exp_err_q.size() == 0) chk("err_queue_empty", {71'h0, addr_err}, 72'h0);
                else chk("addr_err", {71'h0, addr_err}, {71'h0, exp_err_q.pop_front()});
            end else begin
                chk("addr_err_quiet", {71'h0, addr_err}, 72'h0);
            end
        end
    end

    // Memory responder: checks each request against the scoreboard, acks after the queued delay.
    initial begin
        req_t        cur;
        int          dly;
        int          cnt;
        logic [31:0] rdv;
        bit          busy;
        busy = 1'b0;
        dly = 0;
        cnt = 0;
        rdv = 32'h0;
        cur.we = 1'b0;
        cur.addr = 32'h0;
        cur.be = 4'h0;
        cur.wd = 32'h0;
        forever begin
            @(negedge clk);
            if (rst) begin
                ack_r = 1'b0;
                busy = 1'b0;
            end else if (ack_r) begin
                ack_r = 1'b0;
                busy = 1'b0;
                dm_rdata = $urandom;
                chk("req_dropped", {71'h0, dm_req}, 72'h0);
                if (exp_rd_q.size() == 0) chk("rd_queue_empty", 72'h1, 72'h0);
                else chk("rdata_out", {40'h0, rdata_out}, {40'h0, exp_rd_q.pop_front()});
            end else if (dm_req === 1'b1 && !abort_mode) begin
                if (!busy) begin
                    if (exp_req_q.size() == 0) begin
                        chk("unexpected_req", {71'h0, dm_req}, 72'h0);
                    end else begin
                        cur = exp_req_q.pop_front();
                        dly = dly_q.pop_front();
                        rdv = rd_q.pop_front();
                        cnt = 0;
                        busy = 1'b1;
                    end
                end
                if (busy) begin
                    chk("req_fields", {3'h0, dm_we, dm_addr, dm_be, dm_wdata},
                        {3'h0, cur.we, cur.addr, cur.be, cur.wd});
                    if (cnt == dly) begin
                        ack_r = 1'b1;
                        dm_rdata = rdv;
                    end else begin
                        dm_rdata = $urandom;
                    end
                    cnt++;
                end
            end else begin
                dm_rdata = $urandom;
            end
        end
    end

    initial begin
        bit got_req;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_dm", {3'h0, dm_req, dm_we, dm_addr, dm_be, dm_wdata}, 72'h0);
        chk("reset_rdata", {40'h0, rdata_out}, 72'h0);
        chk("reset_stall", {71'h0, stall}, 72'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        issue(1'b1, 2'd0, 1'b0, 32'h1003, 32'h123456AB, 2, 32'h0);
        bubble();
        issue(1'b0, 2'd0, 1'b0, 32'h2001, 32'h0, 0, 32'h11228033);
        chk("lb_value", {40'h0, rdata_out}, {40'h0, 32'hFFFFFF80});
        issue(1'b0, 2'd0, 1'b1, 32'h2001, 32'h0, 0, 32'h11228033);
        chk("lbu_value", {40'h0, rdata_out}, {40'h0, 32'h00000080});
        issue(1'b0, 2'd1, 1'b0, 32'h2002, 32'h0, 1, 32'h9ABC0000);
        chk("lh_value", {40'h0, rdata_out}, {40'h0, 32'hFFFF9ABC});
        issue(1'b0, 2'd1, 1'b1, 32'h2002, 32'h0, 0, 32'h9ABC0000);
        chk("lhu_value", {40'h0, rdata_out}, {40'h0, 32'h00009ABC});
        issue(1'b0, 2'd2, 1'b0, 32'h2002, 32'h0, 0, 32'h0);
        issue(1'b0, 2'd3, 1'b0, 32'h3000, 32'h0, 0, 32'h0);
        bubble();
        issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1, 32'h0);
        issue(1'b1, 2'd2, 1'b0, 32'h14, 32'hCAFEF00D, 0, 32'h0);
        bubble();
        chk("stores_keep_rdata", {40'h0, rdata_out}, {40'h0, 32'h00009ABC});

        // Abort an outstanding load with reset, then deliver a stale ack.
        abort_mode = 1'b1;
        @(posedge clk);
        #1;
        mem_en = 1'b1;
        mem_wr = 1'b0;
        size = 2'd2;
        addr = 32'h40;
        got_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (dm_req === 1'b1) begin
                got_req = 1'b1;
                break;
            end
        end
        chk("abort_req_seen", {71'h0, got_req}, 72'h1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        mem_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        force_ack = 1'b1;
        @(negedge clk);
        chk("abort_req", {71'h0, dm_req}, 72'h0);
        chk("abort_stall", {71'h0, stall}, 72'h0);
        chk("abort_rdata", {40'h0, rdata_out}, 72'h0);
        @(posedge clk);
        #1 force_ack = 1'b0;
        @(negedge clk);
        chk("late_ack_req", {71'h0, dm_req}, 72'h0);
        chk("late_ack_stall", {71'h0, stall}, 72'h0);
        chk("late_ack_rdata", {40'h0, rdata_out}, 72'h0);
        last_ld = 32'h0;
        abort_mode = 1'b0;

        for (int k = 0; k < 300; k++) begin
            logic [1:0]  sz;
            logic [31:0] a;
            sz = 2'($urandom_range(0, 3));
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << (sz == 2'd3 ? 2 : sz)) - 32'd1);
            issue(1'($urandom), sz, 1'($urandom), a, $urandom, $urandom_range(0, 3), $urandom);
            if ($urandom_range(0, 3) == 0) bubble();
        end
        bubble();
        repeat (3) @(negedge clk);
        chk("queues_drained", 72'(exp_req_q.size() + exp_rd_q.size() + exp_err_q.size()), 72'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
